// File: rtl/hazard_scoreboard_fwu_if.sv
// Handshake bundle between ID/EX pipeline control and the hazard/scoreboard unit.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_scoreboard_fwu_if #(
    parameter int AW              = 5,
    parameter int NUM_SRC         = 2,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_SRC*AW-1:0] idRs;
    logic [NUM_SRC-1:0]    idRsUsed;
    logic [AW-1:0]         idRd;
    logic                  idRegWrite;
    logic                  idLong;
    logic [NUM_SRC*AW-1:0] idexRs;
    logic [AW-1:0]         idexRd;
    logic                  idexMemRead;
    logic [AW-1:0]         exmemRd;
    logic [AW-1:0]         memwbRd;
    logic                  exmemRegWrite;
    logic                  memwbRegWrite;
    logic                  lunIssue;
    logic                  lunDone;
    logic [AW-1:0]         lunDoneRd;
    logic [NUM_SRC*2-1:0]  fwdSel;
    logic                  stallId;
    logic [(1<<AW)-1:0]    busyMask;
    logic [OW-1:0]         outstanding;
    logic                  hazErr;

    modport master (
        output idRs, idRsUsed, idRd, idRegWrite, idLong, idexRs, idexRd, idexMemRead,
               exmemRd, memwbRd, exmemRegWrite, memwbRegWrite, lunIssue, lunDone, lunDoneRd,
        input  fwdSel, stallId, busyMask, outstanding, hazErr
    );

    modport slave (
        input  idRs, idRsUsed, idRd, idRegWrite, idLong, idexRs, idexRd, idexMemRead,
               exmemRd, memwbRd, exmemRegWrite, memwbRegWrite, lunIssue, lunDone, lunDoneRd,
        output fwdSel, stallId, busyMask, outstanding, hazErr
    );
endinterface

// File: rtl/hazard_scoreboard_fwu.sv
// Hazard unit for the 5-stage RV32I pipeline: EX operand forwarding, ID stall generation
// and a busy-register scoreboard for long-latency (mul/div) operations.
module hazard_scoreboard_fwu #(
    parameter int AW              = 5,
    parameter int NUM_SRC         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hazard_scoreboard_fwu_if.slave hz
);
    localparam int NREG = 1 << AW;
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW   = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

    logic [NREG-1:0]      busy_r;
    logic [NREG-1:0]      busy_next_s;
    logic [OW-1:0]        out_r;
    logic [OW-1:0]        out_next_s;
    logic [CW-1:0]        stall_cnt_r;
    logic [CW-1:0]        stall_cnt_next_s;
    logic                 haz_err_r;
    logic                 err_event_s;
    logic                 timeout_s;
    logic                 stall_s;
    logic [NUM_SRC*2-1:0] fwd_sel_s;

    // Per-source forwarding select; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_sel_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hz.exmemRegWrite && (hz.exmemRd != '0) && (hz.exmemRd == hz.idexRs[i*AW +: AW])) begin
                fwd_sel_s[i*2 +: 2] = 2'b10;
            end else if (hz.memwbRegWrite && (hz.memwbRd != '0) && (hz.memwbRd == hz.idexRs[i*AW +: AW])) begin
                fwd_sel_s[i*2 +: 2] = 2'b01;
            end else begin
                fwd_sel_s[i*2 +: 2] = 2'b00;
            end
        end
    end

    // ID stall: load-use, RAW/WAW against the scoreboard, or long unit full.
    always_comb begin
        stall_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            stall_s = stall_s
                    | (hz.idexMemRead & (hz.idexRd != '0) & hz.idRsUsed[i]
                       & (hz.idRs[i*AW +: AW] == hz.idexRd))
                    | (hz.idRsUsed[i] & busy_r[hz.idRs[i*AW +: AW]]);
        end
        stall_s = stall_s
                | (hz.idRegWrite & busy_r[hz.idRd])
                | (hz.idLong & (out_r == OW'(MAX_OUTSTANDING)));
    end

    // Scoreboard and in-flight count update; an issue overrides a same-cycle completion.
    always_comb begin
        busy_next_s = busy_r;
        out_next_s  = out_r;
        err_event_s = 1'b0;
        if (hz.lunDone) begin
            if ((hz.lunDoneRd != '0) && busy_r[hz.lunDoneRd]) begin
                busy_next_s[hz.lunDoneRd] = 1'b0;
            end else begin
                err_event_s = 1'b1;
            end
        end else begin
            busy_next_s = busy_r;
        end
        if (hz.lunIssue && (hz.idexRd != '0)) begin
            busy_next_s[hz.idexRd] = 1'b1;
        end else begin
            busy_next_s[0] = 1'b0;
        end
        busy_next_s[0] = 1'b0;
        case ({hz.lunIssue, hz.lunDone})
            2'b10: begin
                if (out_r == OW'(MAX_OUTSTANDING)) begin
                    err_event_s = 1'b1;
                end else begin
                    out_next_s = out_r + OW'(1);
                end
            end
            2'b01: begin
                if (out_r == '0) begin
                    err_event_s = 1'b1;
                end else begin
                    out_next_s = out_r - OW'(1);
                end
            end
            default: out_next_s = out_r;
        endcase
    end

    // Consecutive-stall watchdog, saturating at the timeout.
    always_comb begin
        stall_cnt_next_s = '0;
        timeout_s        = 1'b0;
        if (STALL_TIMEOUT == 0) begin
            stall_cnt_next_s = '0;
        end else if (stall_s) begin
            if (stall_cnt_r == CW'(STALL_TIMEOUT)) begin
                stall_cnt_next_s = stall_cnt_r;
            end else begin
                stall_cnt_next_s = stall_cnt_r + CW'(1);
            end
            timeout_s = (stall_cnt_next_s == CW'(STALL_TIMEOUT));
        end else begin
            stall_cnt_next_s = '0;
        end
    end

    // State registers; hazErr is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= '0;
            out_r       <= '0;
            stall_cnt_r <= '0;
            haz_err_r   <= 1'b0;
        end else begin
            busy_r      <= busy_next_s;
            out_r       <= out_next_s;
            stall_cnt_r <= stall_cnt_next_s;
            haz_err_r   <= haz_err_r | err_event_s | timeout_s;
        end
    end

    assign hz.fwdSel      = fwd_sel_s;
    assign hz.stallId     = stall_s;
    assign hz.busyMask    = busy_r;
    assign hz.outstanding = out_r;
    assign hz.hazErr      = haz_err_r;
endmodule

// File: tb/tb_hazard_scoreboard_fwu.sv
// Directed bench for hazard_scoreboard_fwu: expectations are queued as stimulus is
// applied and drained against the DUT outputs at each sample point.
module tb_hazard_scoreboard_fwu;
    localparam int AW = 5;

    localparam int O_FWD  = 0;
    localparam int O_STL  = 1;
    localparam int O_BUSY = 2;
    localparam int O_OUT  = 3;
    localparam int O_ERR  = 4;

    typedef struct {
        string       tag;
        int          which;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    hazard_scoreboard_fwu_if #(.AW(AW), .NUM_SRC(2), .MAX_OUTSTANDING(4)) hz_if ();

    hazard_scoreboard_fwu #(.AW(AW), .NUM_SRC(2), .MAX_OUTSTANDING(4), .STALL_TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int which);
        case (which)
            O_FWD:   return 32'(hz_if.fwdSel);
            O_STL:   return 32'(hz_if.stallId);
            O_BUSY:  return 32'(hz_if.busyMask);
            O_OUT:   return 32'(hz_if.outstanding);
            default: return 32'(hz_if.hazErr);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int which, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.which = which;
        e.exp   = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.which);
            checks++;
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic clear_inputs();
        hz_if.idRs          = '0;
        hz_if.idRsUsed      = '0;
        hz_if.idRd          = '0;
        hz_if.idRegWrite    = 1'b0;
        hz_if.idLong        = 1'b0;
        hz_if.idexRs        = '0;
        hz_if.idexRd        = '0;
        hz_if.idexMemRead   = 1'b0;
        hz_if.exmemRd       = '0;
        hz_if.memwbRd       = '0;
        hz_if.exmemRegWrite = 1'b0;
        hz_if.memwbRegWrite = 1'b0;
        hz_if.lunIssue      = 1'b0;
        hz_if.lunDone       = 1'b0;
        hz_if.lunDoneRd     = '0;
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        expect_val({tag, "_busy"}, O_BUSY, 32'h0);
        expect_val({tag, "_out"},  O_OUT,  32'h0);
        expect_val({tag, "_err"},  O_ERR,  32'h0);
        drain();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        #2;
        expect_val("rst_busy", O_BUSY, 32'h0);
        expect_val("rst_out",  O_OUT,  32'h0);
        expect_val("rst_err",  O_ERR,  32'h0);
        expect_val("rst_stall", O_STL, 32'h0);
        expect_val("rst_fwd",  O_FWD,  32'h0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Forwarding priority and x0 / write-enable qualification
        hz_if.idexRs = {5'd0, 5'd5};
        hz_if.exmemRd = 5'd5; hz_if.exmemRegWrite = 1'b1;
        hz_if.memwbRd = 5'd5; hz_if.memwbRegWrite = 1'b1;
        expect_val("fwd_exmem_prio", O_FWD, 32'h2);
        settle();
        hz_if.exmemRd = 5'd0;
        expect_val("fwd_memwb", O_FWD, 32'h1);
        settle();
        hz_if.exmemRegWrite = 1'b0; hz_if.memwbRegWrite = 1'b0; hz_if.exmemRd = 5'd5;
        expect_val("fwd_none", O_FWD, 32'h0);
        settle();
        hz_if.idexRs = {5'd6, 5'd5};
        hz_if.exmemRd = 5'd6; hz_if.exmemRegWrite = 1'b1; hz_if.memwbRegWrite = 1'b1;
        expect_val("fwd_two_src", O_FWD, 32'h9);
        settle();
        clear_inputs();

        // Load-use stall
        hz_if.idexMemRead = 1'b1; hz_if.idexRd = 5'd7;
        hz_if.idRs = {5'd7, 5'd0}; hz_if.idRsUsed = 2'b10;
        expect_val("loaduse_stall", O_STL, 32'h1);
        settle();
        hz_if.idRsUsed = 2'b01;
        expect_val("loaduse_unused", O_STL, 32'h0);
        settle();
        hz_if.idexRd = 5'd0; hz_if.idRs = 10'd0; hz_if.idRsUsed = 2'b11;
        expect_val("loaduse_x0", O_STL, 32'h0);
        settle();
        clear_inputs();

        // Long op RAW / WAW through the scoreboard
        hz_if.lunIssue = 1'b1; hz_if.idexRd = 5'd9;
        tick();
        hz_if.lunIssue = 1'b0; hz_if.idexRd = 5'd0;
        hz_if.idRs = {5'd0, 5'd9}; hz_if.idRsUsed = 2'b01;
        expect_val("raw_busy", O_BUSY, 32'h200);
        expect_val("raw_out",  O_OUT,  32'h1);
        expect_val("raw_stall", O_STL, 32'h1);
        settle();
        tick();
        expect_val("raw_stall_hold", O_STL, 32'h1);
        drain();
        hz_if.idRsUsed = 2'b00; hz_if.idRegWrite = 1'b1; hz_if.idRd = 5'd9;
        expect_val("waw_stall", O_STL, 32'h1);
        settle();
        hz_if.idRegWrite = 1'b0; hz_if.idRsUsed = 2'b01;
        hz_if.lunDone = 1'b1; hz_if.lunDoneRd = 5'd9;
        expect_val("done_no_bypass", O_STL, 32'h1);
        settle();
        tick();
        hz_if.lunDone = 1'b0;
        expect_val("done_busy", O_BUSY, 32'h0);
        expect_val("done_out",  O_OUT,  32'h0);
        expect_val("done_stall", O_STL, 32'h0);
        expect_val("done_err",  O_ERR,  32'h0);
        settle();
        clear_inputs();

        // Fill the long unit, then simultaneous issue/complete
        for (int r = 1; r <= 4; r++) begin
            hz_if.lunIssue = 1'b1; hz_if.idexRd = AW'(r);
            tick();
        end
        hz_if.lunIssue = 1'b0; hz_if.idLong = 1'b1;
        expect_val("full_out",   O_OUT,  32'h4);
        expect_val("full_busy",  O_BUSY, 32'h1E);
        expect_val("full_stall", O_STL,  32'h1);
        settle();
        hz_if.lunDone = 1'b1; hz_if.lunDoneRd = 5'd1;
        hz_if.lunIssue = 1'b1; hz_if.idexRd = 5'd5;
        tick();
        expect_val("swap_out",  O_OUT,  32'h4);
        expect_val("swap_busy", O_BUSY, 32'h3C);
        drain();
        hz_if.lunDoneRd = 5'd2; hz_if.idexRd = 5'd2;
        tick();
        expect_val("setwins_busy", O_BUSY, 32'h3C);
        expect_val("setwins_out",  O_OUT,  32'h4);
        expect_val("setwins_err",  O_ERR,  32'h0);
        drain();
        hz_if.lunIssue = 1'b0;
        for (int r = 2; r <= 5; r++) begin
            hz_if.lunDoneRd = AW'(r);
            tick();
        end
        hz_if.lunDone = 1'b0;
        expect_val("drain_out",   O_OUT,  32'h0);
        expect_val("drain_busy",  O_BUSY, 32'h0);
        expect_val("drain_stall", O_STL,  32'h0);
        expect_val("drain_err",   O_ERR,  32'h0);
        settle();
        clear_inputs();

        // Spurious completion sets the sticky error
        hz_if.lunDone = 1'b1; hz_if.lunDoneRd = 5'd3;
        tick();
        hz_if.lunDone = 1'b0;
        expect_val("spur_err",  O_ERR,  32'h1);
        expect_val("spur_busy", O_BUSY, 32'h0);
        expect_val("spur_out",  O_OUT,  32'h0);
        settle();
        repeat (3) tick();
        expect_val("spur_sticky", O_ERR, 32'h1);
        drain();
        pulse_reset("spur_rst");
        tick();

        // Issues to x0 still count; overflow is ignored and flagged
        hz_if.lunIssue = 1'b1; hz_if.idexRd = 5'd0;
        repeat (4) tick();
        expect_val("x0_out",  O_OUT,  32'h4);
        expect_val("x0_busy", O_BUSY, 32'h0);
        expect_val("x0_err",  O_ERR,  32'h0);
        drain();
        tick();
        hz_if.lunIssue = 1'b0;
        expect_val("ovf_out", O_OUT, 32'h4);
        expect_val("ovf_err", O_ERR, 32'h1);
        settle();
        pulse_reset("ovf_rst");
        tick();

        // Stall watchdog
        hz_if.idexMemRead = 1'b1; hz_if.idexRd = 5'd7;
        hz_if.idRs = {5'd0, 5'd7}; hz_if.idRsUsed = 2'b01;
        repeat (63) tick();
        expect_val("wd_63", O_ERR, 32'h0);
        drain();
        tick();
        expect_val("wd_64", O_ERR, 32'h1);
        drain();
        pulse_reset("wd_rst");
        hz_if.lunIssue = 1'b1; hz_if.idexRd = 5'd9;
        tick();
        hz_if.lunIssue = 1'b0; hz_if.idexRd = 5'd7;
        expect_val("mid_busy", O_BUSY, 32'h200);
        settle();
        repeat (30) tick();
        pulse_reset("mid_rst");
        repeat (63) tick();
        expect_val("mid_cnt_cleared", O_ERR, 32'h0);
        drain();
        tick();
        expect_val("mid_timeout", O_ERR, 32'h1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
